// File: rtl/pipe_exe_div_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_exe_div_if
// Description : Pipeline-side bundle for the EXE-stage divider. The pipeline
//               (master) presents a DIV/DIVU request and a flush; the divider
//               (slave) returns the registered quotient/remainder, busy/done
//               status and the combinational stall request.
// Signals     : start, is_signed, dividend, divisor, flush  (master -> slave)
//               q, r, busy, done, stall                      (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_exe_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, is_signed, dividend, divisor, flush,
        input  q, r, busy, done, stall
    );

    modport slave (
        input  start, is_signed, dividend, divisor, flush,
        output q, r, busy, done, stall
    );
endinterface
`default_nettype wire

// File: rtl/pipe_exe_div.sv
`default_nettype none
// ============================================================================
// Module      : pipe_exe_div
// Description : Iterative radix-2 restoring divider for the EXE stage.
//               Implements DIV (two's complement) and DIVU. One quotient bit
//               per cycle; WIDTH+2 cycles from accept to valid q/r. Holds the
//               pipeline through stall while a division is in flight.
// Ports       : clk   - clock, rising edge
//               rst   - synchronous active-high reset
//               bus   - pipe_exe_div_if.slave (request, flush, q/r, status)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_exe_div #(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_exe_div_if.slave     bus
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Working registers
    logic [WIDTH-1:0]   r_quo;      // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_rem;      // partial remainder
    logic [WIDTH-1:0]   r_dvs;      // divisor magnitude
    logic [WIDTH-1:0]   r_dvd_raw;  // untouched dividend, returned as r on divide-by-zero
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [c_CNT_W-1:0] r_cnt;

    // Result / status registers
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_r;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_stall;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic               w_sub_ok;

    // A request arriving together with a flush belongs to a squashed slot.
    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;

    assign w_dvd_mag = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
    assign w_dvs_mag = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

    // The shifted remainder needs one extra bit: with an unsigned divisor of
    // 2^(WIDTH-1) or more, the shifted value can exceed WIDTH bits before the
    // trial subtract brings it back under the divisor.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_sub_ok = !w_diff[WIDTH];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and stall request
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_accept;
                if (w_accept) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_stall = !bus.flush;
                if (bus.flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // q/r are written at the end of this cycle, so the DIV must
                // stay in EXE for it; it advances in the following cycle.
                w_stall     = !bus.flush;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo     <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_dvd_raw <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_cnt     <= '0;
            r_q       <= '0;
            r_r       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_quo     <= w_dvd_mag;
                        r_dvs     <= w_dvs_mag;
                        r_dvd_raw <= bus.dividend;
                        r_neg_q   <= bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg_r   <= bus.is_signed && bus.dividend[WIDTH-1];
                        r_div0    <= (bus.divisor == '0);
                        r_rem     <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_CALC: begin
                    if (!bus.flush) begin
                        r_rem <= w_sub_ok ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_sub_ok};
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                S_DONE: begin
                    if (!bus.flush) begin
                        if (r_div0) begin
                            r_q <= '1;
                            r_r <= r_dvd_raw;
                        end else begin
                            // INT_MIN / -1 needs no special case: the
                            // magnitude quotient 2^(WIDTH-1) is already INT_MIN.
                            r_q <= r_neg_q ? -r_quo : r_quo;
                            r_r <= r_neg_r ? -r_rem : r_rem;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.q     = r_q;
    assign bus.r     = r_r;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.stall = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_pipe_exe_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_exe_div
// Description : Self-checking bench for pipe_exe_div (WIDTH=32). Expected
//               q/r come from a behavioural reference model and are queued
//               when a division is launched, then popped when results land.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_exe_div;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_exe_div_if #(.WIDTH(W)) bus ();

    pipe_exe_div #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000;
                e.r = '0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) return W'($urandom_range(0, 300));
        return $urandom;
    endfunction

    task automatic drive_start(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        sb.push_back(model(sgn, a, b));
    endtask

    // Counts rising edges from the launch until done is seen; checks stall
    // is held every cycle. Optionally disturbs the operands mid-flight.
    task automatic wait_done(input string tag, input logic perturb, output int n);
        logic stall_dropped;
        stall_dropped = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!bus.stall) stall_dropped = 1'b1;
            if (bus.done) break;
            if (perturb && n == 5) begin
                bus.dividend = 32'd999;
                bus.divisor  = 32'd3;
                bus.is_signed = 1'b1;
            end
        end
        check({tag, ".done_seen"}, W'(bus.done), W'(1));
        check({tag, ".stall_held"}, W'(stall_dropped), W'(0));
    endtask

    task automatic check_result(input string tag, input logic exp_stall);
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, W'(sb.size()), W'(1));
        end else begin
            e = sb.pop_front();
            check({tag, ".q"}, bus.q, e.q);
            check({tag, ".r"}, bus.r, e.r);
        end
        check({tag, ".busy_after"},  W'(bus.busy),  W'(0));
        check({tag, ".done_once"},   W'(bus.done),  W'(0));
        check({tag, ".stall_after"}, W'(bus.stall), W'(exp_stall));
    endtask

    task automatic run_one(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic perturb);
        int n;
        drive_start(sgn, a, b);
        #1;
        check({tag, ".stall_T"}, W'(bus.stall), W'(1));
        wait_done(tag, perturb, n);
        check({tag, ".latency"}, W'(n), W'(33));
        bus.start = 1'b0;
        check_result(tag, 1'b0);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check({tag, ".no_done"}, W'(seen), W'(0));
    endtask

    initial begin
        int n1;
        int n2;
        logic [W-1:0] sa [5];
        logic [W-1:0] sbv [5];
        logic         ss [5];

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.flush     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.q",     bus.q,           '0);
        check("reset.r",     bus.r,           '0);
        check("reset.busy",  W'(bus.busy),    W'(0));
        check("reset.done",  W'(bus.done),    W'(0));
        check("reset.stall", W'(bus.stall),   W'(0));
        rst = 1'b0;
        @(negedge clk);

        // Unsigned, with operands disturbed while busy (must be ignored)
        run_one("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b1);

        // Signed and divide-by-zero directed cases
        ss[0] = 1'b1; sa[0] = 32'hFFFF_FF9C; sbv[0] = 32'd7;
        ss[1] = 1'b1; sa[1] = 32'd100;       sbv[1] = 32'hFFFF_FFF9;
        ss[2] = 1'b1; sa[2] = 32'h8000_0000; sbv[2] = 32'hFFFF_FFFF;
        ss[3] = 1'b1; sa[3] = 32'hFFFF_FF9C; sbv[3] = 32'd0;
        ss[4] = 1'b0; sa[4] = 32'd5;         sbv[4] = 32'd0;
        for (int i = 0; i < 5; i++) begin
            run_one($sformatf("directed%0d", i), ss[i], sa[i], sbv[i], 1'b0);
        end
        check("dir.q_m100_7", sb.size() == 0 ? 32'd0 : 32'd1, 32'd0);

        // Establish 14/2, then flush in the middle of CALC
        run_one("pre_flush", 1'b0, 32'd100, 32'd7, 1'b0);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd12345; bus.divisor = 32'd11;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush.busy_before", W'(bus.busy), W'(1));
        bus.flush = 1'b1;
        bus.start = 1'b0;
        #1;
        check("flush.stall", W'(bus.stall), W'(0));
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush.busy", W'(bus.busy), W'(0));
        check("flush.q",    bus.q, 32'd14);
        check("flush.r",    bus.r, 32'd2);
        watch_no_done("flush", 40);
        check("flush.q_hold", bus.q, 32'd14);

        // start together with flush in IDLE is ignored
        bus.start = 1'b1; bus.flush = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
        #1;
        check("startflush.stall", W'(bus.stall), W'(0));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("startflush.busy", W'(bus.busy), W'(0));
        watch_no_done("startflush", 5);

        // Reset in the middle of CALC
        bus.start = 1'b1; bus.dividend = 32'd77; bus.divisor = 32'd4;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst.q",    bus.q, '0);
        check("midrst.r",    bus.r, '0);
        check("midrst.busy", W'(bus.busy), W'(0));
        watch_no_done("midrst", 40);

        // Back-to-back with start held high
        drive_start(1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done("b2b1", 1'b0, n1);
        check("b2b1.latency", W'(n1), W'(33));
        drive_start(1'b0, 32'd9, 32'd3);
        check_result("b2b1", 1'b1);
        wait_done("b2b2", 1'b0, n2);
        check("b2b.done_spacing", W'(n2 + 1), W'(34));
        bus.start = 1'b0;
        check_result("b2b2", 1'b0);

        // Random signed/unsigned operand pairs
        for (int i = 0; i < 1000; i++) begin
            run_one("rand", 1'($urandom_range(0, 1)), pick(), pick(), 1'b0);
        end

        check("sb.drained", W'(sb.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
